// File: rtl/dmem_access_arbiter_if.sv
// Data-memory access bundle: MEM-stage request/response, debug-unit dump stream and memory port.
// The arbiter connects on the slave modport; the surrounding pipeline/memory connects on master.
interface dmem_access_arbiter_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 7
);
  logic                 pipe_read;
  logic                 pipe_write;
  logic [ADDR_SIZE-1:0] pipe_addr;
  logic [DATA_SIZE-1:0] pipe_wr_data;
  logic [DATA_SIZE-1:0] pipe_rd_data;
  logic                 pipe_stall;

  logic                 du_dump_start;
  logic                 du_ready;
  logic                 du_valid;
  logic [DATA_SIZE-1:0] du_data;
  logic                 du_busy;
  logic                 du_done;

  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [DATA_SIZE-1:0] mem_wr_data;
  logic [DATA_SIZE-1:0] mem_rd_data;

  modport slave (
    input  pipe_read, pipe_write, pipe_addr, pipe_wr_data, du_dump_start, du_ready, mem_rd_data,
    output pipe_rd_data, pipe_stall, du_valid, du_data, du_busy, du_done,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output pipe_read, pipe_write, pipe_addr, pipe_wr_data, du_dump_start, du_ready, mem_rd_data,
    input  pipe_rd_data, pipe_stall, du_valid, du_data, du_busy, du_done,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares the single data-memory port between the MEM stage and the debug-unit memory dump.
// While a dump owns the port the pipeline is stalled and no store reaches memory.
module dmem_access_arbiter #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned ADDR_SIZE  = 7,
  parameter int unsigned DUMP_WORDS = 128
) (
  input logic                  i_clk,
  input logic                  i_reset,
  dmem_access_arbiter_if.slave bus
);

  // One extra counter bit lets a full-memory dump finish without address wrap.
  localparam int unsigned     CntW    = ADDR_SIZE + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   du_valid_q, du_valid_d;
  logic [DATA_SIZE-1:0]   du_data_q, du_data_d;
  logic                   du_done_q, du_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    du_valid_d = du_valid_q;
    du_data_d  = du_data_q;
    du_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.du_dump_start) begin
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        du_data_d  = bus.mem_rd_data;
        du_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (du_valid_q && bus.du_ready) begin
          du_valid_d = 1'b0;
          if (cnt_q == LastIdx) begin
            du_done_d = 1'b1;
            state_d   = StDone;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      du_valid_q <= 1'b0;
      du_data_q  <= '0;
      du_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      du_valid_q <= du_valid_d;
      du_data_q  <= du_data_d;
      du_done_q  <= du_done_d;
    end
  end

  // Pipeline owns the port only in idle; otherwise the dump drives it and stores are held off.
  always_comb begin
    bus.mem_addr    = bus.pipe_addr;
    bus.mem_rd_en   = bus.pipe_read;
    bus.mem_wr_en   = bus.pipe_write;
    bus.mem_wr_data = bus.pipe_wr_data;
    bus.pipe_stall  = 1'b0;
    if (state_q != StIdle) begin
      bus.mem_addr   = cnt_q[ADDR_SIZE-1:0];
      bus.mem_rd_en  = (state_q == StRead);
      bus.mem_wr_en  = 1'b0;
      bus.pipe_stall = bus.pipe_read | bus.pipe_write;
    end
  end

  assign bus.pipe_rd_data = bus.mem_rd_data;
  assign bus.du_valid     = du_valid_q;
  assign bus.du_data      = du_data_q;
  assign bus.du_done      = du_done_q;
  assign bus.du_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: behavioural memory plus a shadow copy of what memory should hold,
// with dump words, beat timing and stall behaviour checked against that shadow.
module tb_dmem_access_arbiter;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic [31:0] rd_q;
  logic [31:0] stalled_data;

  dmem_access_arbiter_if #(.DATA_SIZE(32), .ADDR_SIZE(7)) bus ();

  dmem_access_arbiter #(
    .DATA_SIZE  (32),
    .ADDR_SIZE  (7),
    .DUMP_WORDS (DW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory, one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rd_data = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_store(input logic [6:0] addr, input logic [31:0] data);
    bus.pipe_write   = 1'b1;
    bus.pipe_addr    = addr;
    bus.pipe_wr_data = data;
    #1;
    chk("store_stall", bus.pipe_stall, 0);
    chk("store_wr_en", bus.mem_wr_en, 1);
    chk("store_addr", bus.mem_addr, addr);
    chk("store_data", bus.mem_wr_data, data);
    ref_mem[addr] = data;
    tick();
    bus.pipe_write = 1'b0;
  endtask

  task automatic pipe_load(input logic [6:0] addr);
    bus.pipe_read = 1'b1;
    bus.pipe_addr = addr;
    #1;
    chk("load_stall", bus.pipe_stall, 0);
    chk("load_rd_en", bus.mem_rd_en, 1);
    tick();
    bus.pipe_read = 1'b0;
    #1;
    chk("load_data", bus.pipe_rd_data, ref_mem[addr]);
  endtask

  // Each word costs read + wait + send (3 cycles) plus however long ready is held low;
  // done follows the last accepted word by one cycle.
  task automatic run_dump(input bit with_store, input logic [6:0] st_addr,
                          input logic [31:0] st_data, input int hold_word, input int hold_cycles,
                          input int stall_word, input int restart_cyc);
    int idx   = 0;
    int cyc   = 0;
    int last  = 0;
    int held  = 0;
    int dones = 0;
    bit fin   = 1'b0;
    bus.du_dump_start = 1'b1;
    bus.du_ready      = 1'b1;
    if (with_store) begin
      bus.pipe_write   = 1'b1;
      bus.pipe_addr    = st_addr;
      bus.pipe_wr_data = st_data;
    end
    #1;
    chk("start_busy", bus.du_busy, 0);
    if (with_store) begin
      chk("start_store_stall", bus.pipe_stall, 0);
      chk("start_store_wr_en", bus.mem_wr_en, 1);
      chk("start_store_addr", bus.mem_addr, st_addr);
      ref_mem[st_addr] = st_data;
    end
    tick();
    bus.du_dump_start = 1'b0;
    bus.pipe_write    = 1'b0;
    while (!fin && cyc < 300) begin
      cyc++;
      bus.du_ready      = !(idx == hold_word && held < hold_cycles);
      bus.du_dump_start = (cyc == restart_cyc);
      bus.pipe_write    = (idx == stall_word);
      bus.pipe_addr     = 7'd3;
      bus.pipe_wr_data  = stalled_data;
      #1;
      chk("dump_busy", bus.du_busy, 1);
      if (bus.pipe_write) begin
        chk("dump_stall", bus.pipe_stall, 1);
        chk("dump_no_write", bus.mem_wr_en, 0);
      end
      if (bus.du_valid) begin
        chk("dump_word", bus.du_data, ref_mem[idx]);
        if (bus.du_ready) begin
          chk("beat_timing", cyc, last + 3 + held);
          last = cyc;
          held = 0;
          idx++;
        end else begin
          held++;
          chk("hold_no_read", bus.mem_rd_en, 0);
        end
      end
      if (bus.du_done) begin
        dones++;
        chk("done_timing", cyc, last + 1);
        fin = 1'b1;
      end
      tick();
    end
    bus.du_dump_start = 1'b0;
    bus.pipe_write    = 1'b0;
    chk("dump_finished", fin, 1);
    chk("done_count", dones, 1);
    chk("word_count", idx, DW);
    #1;
    chk("post_busy", bus.du_busy, 0);
    chk("post_done", bus.du_done, 0);
    chk("post_valid", bus.du_valid, 0);
    tick();
    chk("no_restart", bus.du_busy, 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.pipe_read     = 1'b0;
    bus.pipe_write    = 1'b0;
    bus.pipe_addr     = '0;
    bus.pipe_wr_data  = '0;
    bus.du_dump_start = 1'b0;
    bus.du_ready      = 1'b0;
    stalled_data      = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.du_valid, 0);
    chk("rst_busy", bus.du_busy, 0);
    chk("rst_done", bus.du_done, 0);
    chk("rst_data", bus.du_data, 0);
    chk("rst_stall", bus.pipe_stall, 0);
    rst = 1'b0;
    tick();

    pipe_store(7'd5, 32'hDEADBEEF);
    pipe_load(7'd5);

    for (int i = 0; i < DW; i++) pipe_store(7'(i), 32'h11 * (i + 1));
    run_dump(1'b0, 7'd0, 32'd0, -1, 0, -1, 0);

    for (int i = 0; i < DW; i++) pipe_store(7'(i), $urandom);
    run_dump(1'b0, 7'd0, 32'd0, 2, 10, -1, 0);

    run_dump(1'b0, 7'd0, 32'd0, -1, 0, 1, 0);
    pipe_store(7'd3, stalled_data);
    pipe_load(7'd3);

    run_dump(1'b1, 7'd9, $urandom, -1, 0, -1, 5);
    pipe_load(7'd9);

    for (int i = 0; i < DW; i++) pipe_store(7'(i), $urandom);
    bus.du_ready      = 1'b0;
    bus.du_dump_start = 1'b1;
    tick();
    bus.du_dump_start = 1'b0;
    for (int k = 0; k < 10 && !bus.du_valid; k++) tick();
    chk("pre_rst_valid", bus.du_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.du_valid, 0);
    chk("mid_rst_busy", bus.du_busy, 0);
    chk("mid_rst_done", bus.du_done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_idle", bus.du_busy, 0);
    run_dump(1'b0, 7'd0, 32'd0, -1, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
